// File: rtl/dispatcher_pkg.sv
// Shared definitions for the instruction dispatcher: FSM state encoding,
// mode codes and the fixed 32-bit instruction field map.
package dispatcher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RETIRE = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam logic [1:0] MODE_RR  = 2'b00;
  localparam logic [1:0] MODE_IMM = 2'b01;

  // Field positions; param2 and the immediate deliberately overlap in [15:14].
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;
  localparam int MODE_MSB   = 27;
  localparam int MODE_LSB   = 26;
  localparam int PARAM1_MSB = 25;
  localparam int PARAM1_LSB = 20;
  localparam int PARAM2_MSB = 19;
  localparam int PARAM2_LSB = 14;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  // Modes 2'b10 and 2'b11 have no sequencer behind them.
  function automatic logic mode_is_legal(input logic [1:0] mode);
    return (mode[1] == 1'b0);
  endfunction

endpackage

// File: rtl/watchdog_counter.sv
// Cycle counter that flags a sequencer which never returns done.
// Cleared while the start pulse is issued, counts while waiting, and
// holds at TIMEOUT-1 where expire is raised.
module watchdog_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] count;

  assign expire = (count == CW'(TIMEOUT - 1));

  // Count waiting cycles, saturating at the expiry value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/instruction_dispatcher.sv
// Initiator side of the start/done handshake: takes one instruction from
// fetch, starts the matching ALU sequencer, holds the operand fields until
// that sequencer answers, then retires (or faults) and returns to IDLE.
module instruction_dispatcher
  import dispatcher_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int OPCODE_W = 4,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [INSTR_W-1:0]  instr,
  output logic                instr_ready,
  output logic                imm_start,
  output logic                rr_start,
  input  logic                imm_done,
  input  logic                rr_done,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   param1,
  output logic [ADDR_W-1:0]   param2,
  output logic [DATA_W-1:0]   immediate,
  output logic                busy,
  output logic                retire,
  output logic                illegal_instr,
  output logic                timeout_fault,
  output logic [CNT_W-1:0]    retired_count
);

  state_t     state;
  state_t     next_state;
  logic [1:0] mode_q;
  logic       fault_is_illegal;
  logic       selected_done;
  logic       wd_expire;
  logic       transfer;

  assign transfer      = (state == ST_IDLE) && instr_valid;
  assign selected_done = (mode_q == MODE_IMM) ? imm_done : rr_done;

  watchdog_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == ST_START),
    .enable (state == ST_WAIT),
    .expire (wd_expire)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; in WAIT a done beats a simultaneous watchdog expiry.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (instr_valid) next_state = ST_DECODE;
      ST_DECODE: next_state = mode_is_legal(mode_q) ? ST_START : ST_FAULT;
      ST_START:  next_state = ST_WAIT;
      ST_WAIT: begin
        if (selected_done) begin
          next_state = ST_RETIRE;
        end else if (wd_expire) begin
          next_state = ST_FAULT;
        end
      end
      ST_RETIRE: next_state = ST_IDLE;
      ST_FAULT:  next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    instr_ready   = (state == ST_IDLE);
    busy          = (state != ST_IDLE);
    imm_start     = (state == ST_START) && (mode_q == MODE_IMM);
    rr_start      = (state == ST_START) && (mode_q == MODE_RR);
    retire        = (state == ST_RETIRE);
    illegal_instr = (state == ST_FAULT) && fault_is_illegal;
    timeout_fault = (state == ST_FAULT) && !fault_is_illegal;
  end

  // Capture the instruction fields on a transfer and hold them until the next one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opcode    <= '0;
      mode_q    <= '0;
      param1    <= '0;
      param2    <= '0;
      immediate <= '0;
    end else if (transfer) begin
      opcode    <= instr[OPCODE_MSB:OPCODE_LSB];
      mode_q    <= instr[MODE_MSB:MODE_LSB];
      param1    <= instr[PARAM1_MSB:PARAM1_LSB];
      param2    <= instr[PARAM2_MSB:PARAM2_LSB];
      immediate <= instr[IMM_MSB:IMM_LSB];
    end
  end

  // Remember which fault FAULT should report; decided while decoding.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fault_is_illegal <= 1'b0;
    end else if (state == ST_DECODE) begin
      fault_is_illegal <= !mode_is_legal(mode_q);
    end
  end

  // Retired-instruction counter, wrapping naturally at its width.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_count <= '0;
    end else if (state == ST_RETIRE) begin
      retired_count <= retired_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Self-checking bench for instruction_dispatcher with a short watchdog and
// a 4-bit retire counter so timeout and wrap-around are reached quickly.
module tb_instruction_dispatcher;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  mode;
    logic [5:0]  p1;
    logic [5:0]  p2;
    logic [15:0] imm;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        imm_start;
  logic        rr_start;
  logic        imm_done;
  logic        rr_done;
  logic [3:0]  opcode;
  logic [5:0]  param1;
  logic [5:0]  param2;
  logic [15:0] immediate;
  logic        busy;
  logic        retire;
  logic        illegal_instr;
  logic        timeout_fault;
  logic [3:0]  retired_count;

  int n_compared   = 0;
  int n_mismatched = 0;
  int imm_start_cnt = 0;
  int rr_start_cnt  = 0;
  int retire_cnt    = 0;
  int illegal_cnt   = 0;
  int timeout_cnt   = 0;
  logic [3:0] model_count = 4'd0;
  exp_t sb[$];

  instruction_dispatcher #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .imm_start     (imm_start),
    .rr_start      (rr_start),
    .imm_done      (imm_done),
    .rr_done       (rr_done),
    .opcode        (opcode),
    .param1        (param1),
    .param2        (param2),
    .immediate     (immediate),
    .busy          (busy),
    .retire        (retire),
    .illegal_instr (illegal_instr),
    .timeout_fault (timeout_fault),
    .retired_count (retired_count)
  );

  always #5 clock = ~clock;

  // Pulse counters, sampled on the falling edge.
  always @(negedge clock) begin
    if (imm_start)     imm_start_cnt++;
    if (rr_start)      rr_start_cnt++;
    if (retire)        retire_cnt++;
    if (illegal_instr) illegal_cnt++;
    if (timeout_fault) timeout_cnt++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "[TB] global time limit");
  end

  function automatic exp_t expect_of(input logic [31:0] w);
    exp_t e;
    e.op   = w[31:28];
    e.mode = w[27:26];
    e.p1   = w[25:20];
    e.p2   = w[19:14];
    e.imm  = w[15:0];
    return e;
  endfunction

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Present a word and let it transfer; returns one cycle later (DECODE).
  task automatic send(input logic [31:0] word);
    int waited = 0;
    while (!instr_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!instr_ready) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL send_ready: instr_ready=%0b required 1", instr_ready);
    end
    instr_valid = 1'b1;
    instr       = word;
    sb.push_back(expect_of(word));
    step();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; instr_valid = 1'b0; instr = '0; imm_done = 1'b0; rr_done = 1'b0;
    step(); step();
    n_compared++;
    if (instr_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_ready: got %b required 1", instr_ready); end
    n_compared++;
    if ({busy, imm_start, rr_start, retire, illegal_instr, timeout_fault} !== 6'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b required 000000", {busy, imm_start, rr_start, retire, illegal_instr, timeout_fault});
    end
    n_compared++;
    if ({opcode, param1, param2, immediate, retired_count} !== 36'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_data: got %h required 0", {opcode, param1, param2, immediate, retired_count});
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_imm();
    exp_t e;
    int   s0 = imm_start_cnt;
    send({4'd3, 2'b01, 6'd5, 6'd0, 14'h00A5});
    n_compared++;
    if (imm_start !== 1'b0) begin n_mismatched++; $display("[TB] FAIL imm_early_start: got %b required 0", imm_start); end
    step();
    e = sb.pop_front();
    n_compared++;
    if ({imm_start, rr_start} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL imm_start_pulse: got %b required 10", {imm_start, rr_start}); end
    n_compared++;
    if ({opcode, param1, immediate} !== {e.op, e.p1, e.imm} || immediate !== 16'h00A5) begin
      n_mismatched++;
      $display("[TB] FAIL imm_fields: got %h required %h", {opcode, param1, immediate}, {e.op, e.p1, e.imm});
    end
    repeat (10) step();
    imm_done = 1'b1;
    step();
    imm_done = 1'b0;
    n_compared++;
    if (retire !== 1'b1) begin n_mismatched++; $display("[TB] FAIL imm_retire: got %b required 1", retire); end
    step();
    model_count = model_count + 4'd1;
    n_compared++;
    if ({instr_ready, busy} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL imm_idle: got %b required 10", {instr_ready, busy}); end
    n_compared++;
    if (retired_count !== model_count) begin n_mismatched++; $display("[TB] FAIL imm_count: got %0d required %0d", retired_count, model_count); end
    n_compared++;
    if (imm_start_cnt - s0 !== 1) begin n_mismatched++; $display("[TB] FAIL imm_start_count: got %0d required 1", imm_start_cnt - s0); end
  endtask

  task automatic test_reset_mid_wait();
    int r0 = retire_cnt;
    send({4'd9, 2'b01, 6'd33, 6'd17, 14'h1ABC});
    step();
    repeat (3) step();
    reset = 1'b0;
    #1;
    n_compared++;
    if ({instr_ready, busy, imm_start, retire, timeout_fault} !== 5'b10000) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset_ctrl: got %b required 10000", {instr_ready, busy, imm_start, retire, timeout_fault});
    end
    n_compared++;
    if ({opcode, param1, param2, immediate, retired_count} !== 36'h0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset_data: got %h required 0", {opcode, param1, param2, immediate, retired_count});
    end
    step();
    reset = 1'b1;
    step(); step();
    sb.delete();
    model_count = 4'd0;
    n_compared++;
    if (retire_cnt !== r0 || timeout_cnt !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset_pulses: retire %0d timeout %0d required %0d 0", retire_cnt - r0, timeout_cnt, 0);
    end
  endtask

  task automatic test_rr_spurious();
    exp_t e;
    int   rr0 = rr_start_cnt;
    int   im0 = imm_start_cnt;
    int   r0  = retire_cnt;
    imm_done = 1'b1;
    send({4'd2, 2'b00, 6'd7, 6'd9, 14'h0123});
    step();
    e = sb.pop_front();
    n_compared++;
    if ({imm_start, rr_start} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL rr_start_pulse: got %b required 01", {imm_start, rr_start}); end
    n_compared++;
    if ({opcode, param1, param2, immediate} !== {e.op, e.p1, e.p2, e.imm}) begin
      n_mismatched++;
      $display("[TB] FAIL rr_fields: got %h required %h", {opcode, param1, param2, immediate}, {e.op, e.p1, e.p2, e.imm});
    end
    repeat (5) step();
    n_compared++;
    if ({busy, retire, retire_cnt - r0} !== {1'b1, 1'b0, 32'd0}) begin
      n_mismatched++;
      $display("[TB] FAIL rr_spurious_ignored: busy %b retire %b retires %0d required 1 0 0", busy, retire, retire_cnt - r0);
    end
    imm_done = 1'b0;
    rr_done  = 1'b1;
    step();
    rr_done = 1'b0;
    n_compared++;
    if (retire !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rr_retire: got %b required 1", retire); end
    step();
    model_count = model_count + 4'd1;
    n_compared++;
    if (retired_count !== model_count) begin n_mismatched++; $display("[TB] FAIL rr_count: got %0d required %0d", retired_count, model_count); end
    n_compared++;
    if (rr_start_cnt - rr0 !== 1 || imm_start_cnt - im0 !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL rr_start_count: rr %0d imm %0d required 1 0", rr_start_cnt - rr0, imm_start_cnt - im0);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] modes [2];
    modes[0] = 2'b11;
    modes[1] = 2'b10;
    for (int m = 0; m < 2; m++) begin
      exp_t e;
      int   il0 = illegal_cnt;
      int   st0 = imm_start_cnt + rr_start_cnt;
      send({4'd5 + 4'(m), modes[m], 6'd12, 6'd40, 14'h2F0F});
      step();
      e = sb.pop_front();
      n_compared++;
      if ({illegal_instr, timeout_fault} !== 2'b10) begin
        n_mismatched++;
        $display("[TB] FAIL illegal_pulse: got %b required 10", {illegal_instr, timeout_fault});
      end
      n_compared++;
      if ({opcode, param1, param2, immediate} !== {e.op, e.p1, e.p2, e.imm}) begin
        n_mismatched++;
        $display("[TB] FAIL illegal_hold: got %h required %h", {opcode, param1, param2, immediate}, {e.op, e.p1, e.p2, e.imm});
      end
      step();
      n_compared++;
      if (instr_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL illegal_idle: got %b required 1", instr_ready); end
      n_compared++;
      if (illegal_cnt - il0 !== 1 || imm_start_cnt + rr_start_cnt - st0 !== 0 || retired_count !== model_count) begin
        n_mismatched++;
        $display("[TB] FAIL illegal_effects: pulses %0d starts %0d count %0d required 1 0 %0d",
                 illegal_cnt - il0, imm_start_cnt + rr_start_cnt - st0, retired_count, model_count);
      end
    end
  endtask

  task automatic test_timeout();
    int k   = 0;
    int to0 = timeout_cnt;
    send({4'd11, 2'b01, 6'd1, 6'd2, 14'h0F00});
    step();
    void'(sb.pop_front());
    while (!timeout_fault && k < 40) begin
      step();
      k++;
    end
    n_compared++;
    if (timeout_fault !== 1'b1 || k !== TIMEOUT + 1) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_latency: fault %b after %0d cycles required 1 after %0d", timeout_fault, k, TIMEOUT + 1);
    end
    n_compared++;
    if ({illegal_instr, retire, retired_count} !== {1'b0, 1'b0, model_count}) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_effects: got %h required %h", {illegal_instr, retire, retired_count}, {1'b0, 1'b0, model_count});
    end
    step();
    send({4'd13, 2'b00, 6'd3, 6'd4, 14'h0055});
    step();
    void'(sb.pop_front());
    repeat (TIMEOUT) step();
    rr_done = 1'b1;
    step();
    rr_done = 1'b0;
    n_compared++;
    if ({retire, timeout_fault} !== 2'b10) begin
      n_mismatched++;
      $display("[TB] FAIL done_on_expiry: got %b required 10", {retire, timeout_fault});
    end
    step();
    model_count = model_count + 4'd1;
    n_compared++;
    if (retired_count !== model_count || timeout_cnt - to0 !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL expiry_count: count %0d faults %0d required %0d 1", retired_count, timeout_cnt - to0, model_count);
    end
  endtask

  task automatic test_wrap_back_to_back();
    localparam int L = 3;
    exp_t e;
    int   guard       = 0;
    int   n_ret       = 0;
    int   last_ret    = -1;
    int   since_start = -1;
    int   idx         = 0;
    while (model_count != 4'd15 && guard < 20) begin
      send({4'd1, 2'b01, 6'd2, 6'd3, 14'h0004});
      step();
      void'(sb.pop_front());
      step();
      imm_done = 1'b1;
      step();
      imm_done = 1'b0;
      step();
      model_count = model_count + 4'd1;
      guard++;
    end
    n_compared++;
    if (retired_count !== 4'd15) begin n_mismatched++; $display("[TB] FAIL preload_count: got %0d required 15", retired_count); end

    instr       = {4'd1, 2'b01, 6'd10, 6'd0, 14'd5};
    instr_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && n_ret < 4; cyc++) begin
      if (instr_ready && instr_valid) begin
        sb.push_back(expect_of(instr));
        n_compared++;
        if (retired_count !== model_count) begin
          n_mismatched++;
          $display("[TB] FAIL b2b_count: got %0d required %0d", retired_count, model_count);
        end
      end
      if (imm_start) begin
        e = sb.pop_front();
        n_compared++;
        if ({opcode, param1, param2, immediate} !== {e.op, e.p1, e.p2, e.imm}) begin
          n_mismatched++;
          $display("[TB] FAIL b2b_fields: got %h required %h", {opcode, param1, param2, immediate}, {e.op, e.p1, e.p2, e.imm});
        end
        idx++;
        instr = {4'(idx + 1), 2'b01, 6'(idx + 10), 6'(idx), 14'(idx * 37 + 5)};
        since_start = 0;
      end else if (since_start >= 0) begin
        since_start++;
      end
      imm_done = (since_start == L);
      if (imm_done) since_start = -1;
      if (retire) begin
        model_count = model_count + 4'd1;
        if (last_ret >= 0) begin
          n_compared++;
          if (cyc - last_ret !== 4 + L) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_period: got %0d cycles required %0d", cyc - last_ret, 4 + L);
          end
        end
        last_ret = cyc;
        n_ret++;
      end
      step();
    end
    instr_valid = 1'b0;
    imm_done    = 1'b0;
    step(); step(); step();
    n_compared++;
    if (n_ret !== 4) begin n_mismatched++; $display("[TB] FAIL b2b_retires: got %0d required 4", n_ret); end
    n_compared++;
    if (retired_count !== model_count) begin n_mismatched++; $display("[TB] FAIL wrap_count: got %0d required %0d", retired_count, model_count); end
  endtask

  initial begin
    test_reset();
    test_imm();
    test_reset_mid_wait();
    test_rr_spurious();
    test_illegal();
    test_timeout();
    test_wrap_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
